// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared width constants, operand record and round-robin search for adder_arbiter
package adder_arb_pkg;
    localparam int ADD_W     = 32;
    localparam int N_REQ_DEF = 4;
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic [IDX_W-1:0] id;
    } op_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // first set bit of valid at or after ptr, wrapping modulo n; lowest offset wins
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [IDX_W-1:0] ptr, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && valid[j]) begin
                p.found = 1'b1;
                p.idx   = IDX_W'(j);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/Add.sv
// Add: 32-bit ripple-carry adder shared by all requesters of adder_arbiter
module Add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic cy;

    // carry ripples from bit 0 upward; the final carry-out is dropped
    always_comb begin
        cy  = 1'b0;
        sum = '0;
        for (int k = 0; k < 32; k++) begin
            sum[k] = a[k] ^ b[k] ^ cy;
            cy     = (a[k] & b[k]) | (cy & (a[k] ^ b[k]));
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant with a pointer that moves past each accepted winner
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] valid,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  win
);
    logic [ID_W-1:0]    ptr;
    logic [MAX_REQ-1:0] valid_x;
    pick_t              pick;

    // search from the pointer; grant only when downstream has room and not in reset
    always_comb begin
        valid_x              = '0;
        valid_x[N_REQ-1:0]   = valid;
        pick                 = rr_pick(valid_x, IDX_W'(ptr), N_REQ);
        win                  = ID_W'(pick.idx);
        grant                = (pick.found && en && rst_n) ? (N_REQ'(1) << win) : '0;
    end

    // pointer moves to the requester after the one just accepted, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (|(grant & valid))
            ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: N_REQ requesters share one Add through a 2-stage valid/ready pipeline.
// Optional ADDER_ARB_CARRY_EN adds a registered rsp_carry output.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = 2,
    parameter int W     = ADD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_sum,
    output logic [ID_W-1:0]    rsp_id
`ifdef ADDER_ARB_CARRY_EN
    ,
    output logic               rsp_carry
`endif
);
    op_t             op;
    logic            op_vld;
    logic [W-1:0]    sum;
    logic [ID_W-1:0] win;
    logic            stage1_free;
    logic            stage2_free;
    logic            take;

    assign stage2_free = !rsp_valid || rsp_ready;
    assign stage1_free = !op_vld || stage2_free;
    assign take        = |(req_valid & req_ready);

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .en    (stage1_free),
        .grant (req_ready),
        .win   (win)
    );

    Add u_add (
        .a   (op.a),
        .b   (op.b),
        .sum (sum)
    );

    // operand stage: load the accepted requester, or go empty when free and idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld <= 1'b0;
            op     <= '0;
        end else if (stage1_free) begin
            op_vld <= take;
            if (take)
                op <= {req_a[int'(win)*W +: W], req_b[int'(win)*W +: W], IDX_W'(win)};
        end
    end

    // result stage: capture the adder output while it can move, else hold for downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else if (stage2_free) begin
            rsp_valid <= op_vld;
            if (op_vld) begin
                rsp_sum <= sum;
                rsp_id  <= ID_W'(op.id);
            end
        end
    end

`ifdef ADDER_ARB_CARRY_EN
    // a wrapped sum is smaller than either operand, which marks the carry-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_carry <= 1'b0;
        else if (stage2_free && op_vld)
            rsp_carry <= sum < op.a;
    end
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random traffic checked against a transaction-level model
module tb_adder_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a, req_b;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_sum;
    logic [IW-1:0]     rsp_id;
`ifdef ADDER_ARB_CARRY_EN
    logic              rsp_carry;
`endif
    logic [31:0]       a [N];
    logic [31:0]       b [N];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_pack
        assign req_a[g*32 +: 32] = a[g];
        assign req_b[g*32 +: 32] = b[g];
    end

    adder_arbiter #(.N_REQ(N), .ID_W(IW), .W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef ADDER_ARB_CARRY_EN
        ,
        .rsp_carry (rsp_carry)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          ptr;
    bit          s1_v, s2_v, s2_c;
    logic [31:0] s1_a, s1_b, s2_sum;
    int          s1_id, s2_id;
    logic [N-1:0] acc;
    int          acc_cnt;
    int          got_id [$];
    logic [31:0] got_sum [$];
    bit          got_c [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0; s1_v = 0; s2_v = 0; s2_c = 0; s2_sum = '0; s2_id = 0;
        acc = '0;
        got_id.delete(); got_sum.delete(); got_c.delete();
    endtask

    // one clock: compare, advance the model across the edge, return at negedge+1
    task automatic cycle();
        int  w;
        bit  free1, free2;
        logic [32:0] wide;
        #1;
        w     = winner();
        free2 = !s2_v || rsp_ready;
        free1 = !s1_v || free2;
        chk("req_ready", 32'(req_ready), (free1 && w >= 0) ? 32'(1 << w) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'(s2_v));
        if (s2_v) begin
            chk("rsp_sum", rsp_sum, s2_sum);
            chk("rsp_id", 32'(rsp_id), 32'(s2_id));
`ifdef ADDER_ARB_CARRY_EN
            chk("rsp_carry", 32'(rsp_carry), 32'(s2_c));
`endif
        end
        if (rsp_valid && rsp_ready) begin
            got_id.push_back(int'(rsp_id));
            got_sum.push_back(rsp_sum);
`ifdef ADDER_ARB_CARRY_EN
            got_c.push_back(rsp_carry);
`else
            got_c.push_back(1'b0);
`endif
        end
        acc = '0;
        if (free2) begin
            s2_v = s1_v;
            if (s1_v) begin
                wide   = {1'b0, s1_a} + {1'b0, s1_b};
                s2_sum = wide[31:0];
                s2_c   = wide[32];
                s2_id  = s1_id;
            end
        end
        if (free1) begin
            s1_v = (w >= 0);
            if (w >= 0) begin
                s1_a = a[w]; s1_b = b[w]; s1_id = w;
                ptr = (w + 1) % N;
                acc[w] = 1'b1;
                acc_cnt++;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_sum", rsp_sum, 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] pick();
        return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end
        @(negedge clk);
        #1;
        do_reset();

        // single requester: 5+7 from requester 0, result two edges after accept
        a[0] = 32'd5; b[0] = 32'd7; req_valid = 4'b0001; rsp_ready = 1'b1;
        #1;
        chk("single ready", 32'(req_ready), 32'h1);
        cycle();
        req_valid = '0;
        chk("single no rsp yet", 32'(rsp_valid), 32'd0);
        cycle();
        chk("single rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single sum", rsp_sum, 32'd12);
        chk("single id", 32'(rsp_id), 32'd0);
        cycle();

        // all valid, rsp_ready high: ids 0,1,2,3,0.. with sums i*16+1
        do_reset();
        for (int i = 0; i < N; i++) begin a[i] = 32'(i * 16); b[i] = 32'd1; end
        req_valid = '1; rsp_ready = 1'b1;
        for (int c = 0; c < 30 && got_id.size() < 8; c++) cycle();
        chk("rr count", 32'(got_id.size()), 32'd8);
        for (int k = 0; k < 8 && k < got_id.size(); k++) begin
            chk("rr id", 32'(got_id[k]), 32'(k % 4));
            chk("rr sum", got_sum[k], 32'((k % 4) * 16 + 1));
        end

        // backpressure: two accepts fill the pipe, then ready drops and outputs hold
        do_reset();
        req_valid = '1; rsp_ready = 1'b0; acc_cnt = 0;
        repeat (4) cycle();
        chk("bp accepts", 32'(acc_cnt), 32'd2);
        chk("bp ready", 32'(req_ready), 32'd0);
        chk("bp hold sum", rsp_sum, 32'd1);
        chk("bp hold id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && got_id.size() < 4; c++) cycle();
        chk("bp count", 32'(got_id.size()), 32'd4);
        for (int k = 0; k < 4 && k < got_id.size(); k++)
            chk("bp order", 32'(got_id[k]), 32'(k));

        // wrap-around: all ones plus one
        do_reset();
        a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        for (int c = 0; c < 10 && got_sum.size() < 1; c++) cycle();
        chk("wrap count", 32'(got_sum.size()), 32'd1);
        if (got_sum.size() > 0) begin
            chk("wrap sum", got_sum[0], 32'd0);
`ifdef ADDER_ARB_CARRY_EN
            chk("wrap carry", 32'(got_c[0]), 32'd1);
`endif
        end

        // pointer skip: pointer parked at 2, requesters 0 and 3 alternate starting with 3
        do_reset();
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b1001;
        #1;
        chk("skip first", 32'(req_ready), 32'h8);
        cycle();
        chk("skip second", 32'(req_ready), 32'h1);
        cycle();
        chk("skip third", 32'(req_ready), 32'h8);
        cycle();

        // reset while both stages hold data: everything in flight is dropped
        req_valid = '1;
        repeat (3) cycle();
        chk("midreset op loaded", 32'(s1_v), 32'd1);
        do_reset();
        req_valid = '1;
        #1;
        chk("post reset grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        cycle();
        chk("post reset no rsp", 32'(rsp_valid), 32'd0);
        cycle();

        // random traffic, valid held stable until accepted
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = $urandom_range(0, 2) != 0;
                    a[i] = pick();
                    b[i] = pick();
                end
            rsp_ready = $urandom_range(0, 3) != 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
